// File: rtl/io_bus_sequencer.sv
// Multi-cycle sequencer for memory-mapped I/O: decodes the peripheral slot, runs a req/ack
// handshake with timeout, stalls the CPU until completion and reports unmapped/unresponsive accesses.
module io_bus_sequencer #(
    parameter int DATA_W  = 32,
    parameter int NUM_DEV = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      IORead,
    input  logic                      IOWrite,
    input  logic [9:0]                io_addr,
    input  logic [DATA_W-1:0]         io_wdata,
    input  logic                      err_clr,
    output logic                      cpu_stall,
    output logic [DATA_W-1:0]         io_rdata,
    output logic [NUM_DEV-1:0]        dev_req,
    output logic                      dev_we,
    output logic [1:0]                dev_offs,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]        dev_ack,
    output logic                      io_error,
    output logic [9:0]                err_addr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e              state_q,     state_d;
    logic [NUM_DEV-1:0]  dev_req_q,   dev_req_d;
    logic                dev_we_q,    dev_we_d;
    logic [1:0]          dev_offs_q,  dev_offs_d;
    logic [DATA_W-1:0]   dev_wdata_q, dev_wdata_d;
    logic [DATA_W-1:0]   io_rdata_q,  io_rdata_d;
    logic                io_error_q,  io_error_d;
    logic [9:0]          err_addr_q,  err_addr_d;
    logic [9:0]          addr_q,      addr_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic                io_go;
    logic                mapped;
    logic                ack_hit;
    logic                err_set;
    logic [DATA_W-1:0]   rdata_sel;

    assign io_go     = IORead | IOWrite;
    assign mapped    = (io_addr[9:6] == 4'b0000);
    // Only an ack from the slot currently being requested can complete the access.
    assign ack_hit   = |(dev_ack & dev_req_q);
    assign rdata_sel = dev_rdata[int'(addr_q[5:4]) * DATA_W +: DATA_W];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        dev_req_d   = dev_req_q;
        dev_we_d    = dev_we_q;
        dev_offs_d  = dev_offs_q;
        dev_wdata_d = dev_wdata_q;
        io_rdata_d  = io_rdata_q;
        err_addr_d  = err_addr_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_set     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (io_go) begin
                    if (mapped) begin
                        dev_req_d   = NUM_DEV'(1) << io_addr[5:4];
                        dev_we_d    = IOWrite;
                        dev_offs_d  = io_addr[3:2];
                        dev_wdata_d = io_wdata;
                        addr_d      = io_addr;
                        cnt_d       = '0;
                        // A simultaneous read+write runs as a write and returns zero.
                        if (IORead && IOWrite) begin
                            io_rdata_d = '0;
                        end
                        state_d = S_ACCESS;
                    end else begin
                        err_set    = 1'b1;
                        err_addr_d = io_addr;
                        io_rdata_d = '0;
                        state_d    = S_DONE;
                    end
                end
            end

            S_ACCESS: begin
                if (ack_hit) begin
                    if (!dev_we_q) begin
                        io_rdata_d = rdata_sel;
                    end
                    dev_req_d = '0;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    dev_req_d  = '0;
                    io_rdata_d = '0;
                    err_set    = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new error outranks a clear arriving in the same cycle.
        io_error_d = err_set | (io_error_q & ~err_clr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dev_req_q   <= '0;
            dev_we_q    <= 1'b0;
            dev_offs_q  <= '0;
            dev_wdata_q <= '0;
            io_rdata_q  <= '0;
            io_error_q  <= 1'b0;
            err_addr_q  <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
            state_q     <= state_d;
            dev_req_q   <= dev_req_d;
            dev_we_q    <= dev_we_d;
            dev_offs_q  <= dev_offs_d;
            dev_wdata_q <= dev_wdata_d;
            io_rdata_q  <= io_rdata_d;
            io_error_q  <= io_error_d;
            err_addr_q  <= err_addr_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // The IDLE term is combinational so the PC never advances on the issuing cycle.
    assign cpu_stall = ((state_q == S_IDLE) & io_go) | (state_q == S_ACCESS);
    assign io_rdata  = io_rdata_q;
    assign dev_req   = dev_req_q;
    assign dev_we    = dev_we_q;
    assign dev_offs  = dev_offs_q;
    assign dev_wdata = dev_wdata_q;
    assign io_error  = io_error_q;
    assign err_addr  = err_addr_q;

endmodule
